// File: rtl/beat_scheduler.sv
// Game-flow sequencer: phase FSM, beat-driven spawn pacing, round length, level and lives.
// Define SCHED_LIVES_EN to let incorrect hits consume lives and end the round early.
module beat_scheduler #(
  parameter int unsigned ROUND_BEATS     = 64,
  parameter int unsigned COUNTDOWN_BEATS = 4,
  parameter int unsigned HITS_PER_LEVEL  = 8,
  parameter int unsigned MAX_LEVEL       = 3,
  parameter int unsigned LIVES           = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       beat_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       correct_hit,
  input  logic       incorrect_hit,
  output logic [2:0] game_state,
  output logic       spawn,
  output logic [1:0] level,
  output logic [7:0] beats_left,
  output logic [1:0] lives,
  output logic       round_done
);

  localparam logic [7:0] RoundBeats     = 8'(ROUND_BEATS);
  localparam logic [7:0] CountdownBeats = 8'(COUNTDOWN_BEATS);
  localparam logic [3:0] HitsPerLevel   = 4'(HITS_PER_LEVEL);
  localparam logic [1:0] MaxLevel       = 2'(MAX_LEVEL);
  localparam logic [1:0] InitLives      = 2'(LIVES);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCountdown = 3'd1,
    StPlay      = 3'd2,
    StPause     = 3'd3,
    StOver      = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] beats_left_q, beats_left_d;
  logic [1:0] level_q, level_d;
  logic [1:0] lives_q, lives_d;
  logic [3:0] hit_cnt_q, hit_cnt_d;
  logic [1:0] phase_q, phase_d;
  logic       spawn_q, spawn_d;
  logic       round_done_q, round_done_d;

  logic       credit;
  logic       miss;
  logic       lives_out;

  // A simultaneous incorrect hit always voids the correct one.
  assign credit = correct_hit & ~incorrect_hit;

  always_comb begin
    miss      = 1'b0;
    lives_out = 1'b0;
`ifdef SCHED_LIVES_EN
    miss      = incorrect_hit;
    lives_out = incorrect_hit && (lives_q == 2'd1);
`endif
  end

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    level_d      = level_q;
    lives_d      = lives_q;
    hit_cnt_d    = hit_cnt_q;
    phase_d      = phase_q;
    spawn_d      = 1'b0;
    round_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StCountdown;
          beats_left_d = CountdownBeats;
          level_d      = 2'd0;
          lives_d      = InitLives;
          hit_cnt_d    = 4'd0;
        end
      end

      StCountdown: begin
        if (beat_tick) begin
          if (beats_left_q == 8'd1) begin
            state_d      = StPlay;
            beats_left_d = RoundBeats;
            phase_d      = 2'd0;
          end else begin
            beats_left_d = beats_left_q - 8'd1;
          end
        end
      end

      StPlay: begin
        if (pause) begin
          // Pause entry swallows any beat or hit arriving in the same cycle.
          state_d = StPause;
        end else if (lives_out) begin
          state_d      = StOver;
          lives_d      = 2'd0;
          round_done_d = 1'b1;
        end else begin
          if (miss) begin
            lives_d = lives_q - 2'd1;
          end
          if (beat_tick) begin
            beats_left_d = beats_left_q - 8'd1;
            if (phase_q == 2'd0) begin
              spawn_d = 1'b1;
              phase_d = MaxLevel - level_q;
            end else begin
              phase_d = phase_q - 2'd1;
            end
            if (beats_left_q == 8'd1) begin
              state_d      = StOver;
              round_done_d = 1'b1;
            end
          end
          if (credit) begin
            if (4'(hit_cnt_q + 4'd1) == HitsPerLevel) begin
              hit_cnt_d = 4'd0;
              if (level_q != MaxLevel) begin
                level_d = level_q + 2'd1;
              end
            end else begin
              hit_cnt_d = hit_cnt_q + 4'd1;
            end
          end
        end
      end

      StPause: begin
        if (start) begin
          state_d = StIdle;
        end else if (!pause) begin
          state_d = StPlay;
        end
      end

      StOver: begin
        if (start) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      beats_left_q <= 8'd0;
      level_q      <= 2'd0;
      lives_q      <= InitLives;
      hit_cnt_q    <= 4'd0;
      phase_q      <= 2'd0;
      spawn_q      <= 1'b0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      hit_cnt_q    <= hit_cnt_d;
      phase_q      <= phase_d;
      spawn_q      <= spawn_d;
      round_done_q <= round_done_d;
    end
  end

  assign game_state = state_q;
  assign spawn      = spawn_q;
  assign level      = level_q;
  assign beats_left = beats_left_q;
  assign lives      = lives_q;
  assign round_done = round_done_q;

endmodule

// File: tb/tb_beat_scheduler.sv
// Randomized bench for beat_scheduler against a count-based behavioural model.
module tb_beat_scheduler;

  localparam int RoundBeats = 24;
  localparam int CdBeats    = 3;
  localparam int HitsPerLvl = 3;
  localparam int MaxLvl     = 3;
  localparam int InitLives  = 3;
  localparam int NumCycles  = 8000;
`ifdef SCHED_LIVES_EN
  localparam bit LivesEn = 1'b1;
`else
  localparam bit LivesEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       beat_tick;
  logic       start;
  logic       pause;
  logic       correct_hit;
  logic       incorrect_hit;
  logic [2:0] game_state;
  logic       spawn;
  logic [1:0] level;
  logic [7:0] beats_left;
  logic [1:0] lives;
  logic       round_done;

  int checks = 0;
  int errors = 0;

  // Model: state plus event counts; outputs derived arithmetically.
  int m_state;
  int m_beats;
  int m_spawn;
  int m_done;
  int cd_count;
  int play_beat;
  int next_spawn;
  int total_hits;
  int misses;

  always #5 clk = ~clk;

  beat_scheduler #(
    .ROUND_BEATS    (RoundBeats),
    .COUNTDOWN_BEATS(CdBeats),
    .HITS_PER_LEVEL (HitsPerLvl),
    .MAX_LEVEL      (MaxLvl),
    .LIVES          (InitLives)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .beat_tick    (beat_tick),
    .start        (start),
    .pause        (pause),
    .correct_hit  (correct_hit),
    .incorrect_hit(incorrect_hit),
    .game_state   (game_state),
    .spawn        (spawn),
    .level        (level),
    .beats_left   (beats_left),
    .lives        (lives),
    .round_done   (round_done)
  );

  task automatic check_eq(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, observed, expected);
    end
  endtask

  function automatic int m_level();
    int l;
    l = total_hits / HitsPerLvl;
    return (l > MaxLvl) ? MaxLvl : l;
  endfunction

  task automatic model_reset();
    m_state    = 0;
    m_beats    = 0;
    m_spawn    = 0;
    m_done     = 0;
    cd_count   = 0;
    play_beat  = 0;
    next_spawn = 1;
    total_hits = 0;
    misses     = 0;
  endtask

  task automatic model_step();
    m_spawn = 0;
    m_done  = 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    case (m_state)
      0: if (start) begin
        m_state    = 1;
        cd_count   = 0;
        m_beats    = CdBeats;
        total_hits = 0;
        misses     = 0;
      end
      1: if (beat_tick) begin
        cd_count++;
        m_beats = CdBeats - cd_count;
        if (cd_count == CdBeats) begin
          m_state    = 2;
          play_beat  = 0;
          next_spawn = 1;
          m_beats    = RoundBeats;
        end
      end
      2: begin
        if (pause) begin
          m_state = 3;
        end else if (LivesEn && incorrect_hit && (InitLives - misses == 1)) begin
          misses++;
          m_state = 4;
          m_done  = 1;
        end else begin
          if (LivesEn && incorrect_hit) misses++;
          if (beat_tick) begin
            play_beat++;
            m_beats = RoundBeats - play_beat;
            if (play_beat == next_spawn) begin
              m_spawn    = 1;
              next_spawn = play_beat + (MaxLvl - m_level()) + 1;
            end
            if (play_beat == RoundBeats) begin
              m_state = 4;
              m_done  = 1;
            end
          end
          if (correct_hit && !incorrect_hit) total_hits++;
        end
      end
      3: begin
        if (start) m_state = 0;
        else if (!pause) m_state = 2;
      end
      default: if (start) m_state = 0;
    endcase
  endtask

  task automatic compare_all();
    check_eq("game_state", int'(game_state), m_state);
    check_eq("spawn", int'(spawn), m_spawn);
    check_eq("level", int'(level), m_level());
    check_eq("beats_left", int'(beats_left), m_beats);
    check_eq("lives", int'(lives), InitLives - misses);
    check_eq("round_done", int'(round_done), m_done);
  endtask

  initial begin
    reset_n       = 1'b0;
    beat_tick     = 1'b0;
    start         = 1'b0;
    pause         = 1'b0;
    correct_hit   = 1'b0;
    incorrect_hit = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();

    for (int i = 0; i < NumCycles; i++) begin
      @(negedge clk);
      reset_n       = ($urandom_range(0, 399) != 0);
      beat_tick     = ($urandom_range(0, 1) == 0);
      start         = (m_state == 0 || m_state == 4) ? ($urandom_range(0, 3) == 0)
                                                     : ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      correct_hit   = ($urandom_range(0, 2) == 0);
      incorrect_hit = ($urandom_range(0, 11) == 0);
      model_step();
      @(posedge clk);
      #1;
      compare_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
